// File: rtl/interp_filter_pkg.sv
// interp_filter_pkg
// Shared constants and types for the interpolate-by-2 symmetric FIR.
// C_COEF holds the even-indexed taps c[k] = h[2k] of the 16-tap prototype;
// the odd taps follow from symmetry as h[2k+1] = c[7-k].
// Phase gain (sum of c[k]) is slightly above unity, so full-scale DC input
// exercises the output clamp/wrap path.
package interp_filter_pkg;

    localparam int COEFF_COUNT_DEFAULT = 16;
    localparam int DATA_WIDTH_DEFAULT  = 18;
    localparam int COEFF_WIDTH_DEFAULT = 18;
    localparam int ROUND_SHIFT_DEFAULT = 17;
    localparam int COEFF_UNIQUE        = COEFF_COUNT_DEFAULT / 2;

    typedef logic signed [COEFF_WIDTH_DEFAULT-1:0] coef_t;

    // Full impulse response h[0..15]:
    //   -600 -1500 2500 6000 -9000 -15000 40000 110000
    //   110000 40000 -15000 -9000 6000 2500 -1500 -600
    localparam coef_t C_COEF [COEFF_UNIQUE] = '{
        -18'sd600,
         18'sd2500,
        -18'sd9000,
         18'sd40000,
         18'sd110000,
        -18'sd15000,
         18'sd6000,
        -18'sd1500
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC0 = 2'd1,
        ST_MAC1 = 2'd2
    } state_t;

endpackage

// File: rtl/interp_round_sat.sv
// interp_round_sat
// Registered output stage: symmetric round-half-away-from-zero of the MAC
// accumulator, then either clamp or two's-complement wrap to DataWidth.
// Build macro INTERP_FILTER_SATURATE_EN selects the clamp; without it the
// rounded value is truncated to its DataWidth LSBs.
// Data_o holds its value between valid pulses.
module interp_round_sat
    import interp_filter_pkg::*;
#(
    parameter int AccWidth   = 39,
    parameter int DataWidth  = DATA_WIDTH_DEFAULT,
    parameter int RoundShift = ROUND_SHIFT_DEFAULT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_vld,
    input  logic signed [AccWidth-1:0]  i_acc,
    output logic                        o_vld,
    output logic signed [DataWidth-1:0] o_data
);

    // One guard bit keeps the bias addition from overflowing.
    localparam int ExtWidth = AccWidth + 1;
    localparam int ShWidth  = ExtWidth - RoundShift;

`ifdef INTERP_FILTER_SATURATE_EN
    localparam logic signed [ShWidth-1:0] MaxVal =
        {{(ShWidth-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
    localparam logic signed [ShWidth-1:0] MinVal = ~MaxVal;
`endif

    logic                        r_vld_p2;
    logic signed [DataWidth-1:0] r_data_p2;

    // Bias is half an LSB for positive values and one less for negative ones,
    // so the following arithmetic shift rounds ties away from zero.
    function automatic logic signed [ShWidth-1:0] round_sym(
        input logic signed [AccWidth-1:0] acc
    );
        logic signed [ExtWidth-1:0] ext;
        logic signed [ExtWidth-1:0] bias;
        logic signed [ExtWidth-1:0] sum;
        ext  = {acc[AccWidth-1], acc};
        bias = ExtWidth'(1) <<< (RoundShift - 1);
        if (acc[AccWidth-1]) begin
            bias = bias - ExtWidth'(1);
        end
        sum = ext + bias;
        return sum[ExtWidth-1:RoundShift];
    endfunction

    // Reduce the rounded value to the output word width.
    function automatic logic signed [DataWidth-1:0] limit(
        input logic signed [ShWidth-1:0] v
    );
`ifdef INTERP_FILTER_SATURATE_EN
        logic signed [DataWidth-1:0] res;
        if (v > MaxVal) begin
            res = {1'b0, {(DataWidth-1){1'b1}}};
        end else if (v < MinVal) begin
            res = {1'b1, {(DataWidth-1){1'b0}}};
        end else begin
            res = v[DataWidth-1:0];
        end
        return res;
`else
        return v[DataWidth-1:0];
`endif
    endfunction

    // ---- stage p2: rounded, width-limited output word ----
    // Output register: capture a new word only when the accumulator is final.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
        end else begin
            r_vld_p2 <= i_vld;
            if (i_vld) begin
                r_data_p2 <= limit(round_sym(i_acc));
            end
        end
    end

    assign o_vld  = r_vld_p2;
    assign o_data = r_data_p2;

endmodule

// File: rtl/interp_symmetric_filter.sv
// interp_symmetric_filter
// Interpolate-by-2 FIR with a single multiply-accumulate per cycle.
// Each accepted sample runs two MAC phases of CoeffCount/2 cycles: phase 0
// walks c[k] forward (even outputs), phase 1 walks the same stored set
// backwards (odd outputs, by tap symmetry). Samples offered while busy are
// dropped and latch the sticky overrun flag.
// Build macro INTERP_FILTER_SATURATE_EN: clamp the rounded output instead of
// wrapping it (handled in interp_round_sat).
module interp_symmetric_filter
    import interp_filter_pkg::*;
#(
    parameter int CoeffCount = COEFF_COUNT_DEFAULT,
    parameter int DataWidth  = DATA_WIDTH_DEFAULT,
    parameter int CoeffWidth = COEFF_WIDTH_DEFAULT,
    parameter int RoundShift = ROUND_SHIFT_DEFAULT
) (
    input  logic                        Clk_i,
    input  logic                        Rst_i,
    input  logic signed [DataWidth-1:0] Data_i,
    input  logic                        DataNd_i,
    output logic                        Ready_o,
    output logic signed [DataWidth-1:0] Data_o,
    output logic                        DataValid_o,
    output logic                        Overrun_o
);

    localparam int Half      = CoeffCount / 2;
    localparam int CntWidth  = (Half > 1) ? $clog2(Half) : 1;
    localparam int ProdWidth = DataWidth + CoeffWidth;
    localparam int AccWidth  = ProdWidth + $clog2(Half);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [CntWidth-1:0]          r_cnt;
    logic                         w_last;
    logic                         w_accept;
    logic                         r_overrun;

    logic signed [DataWidth-1:0]  r_dl [Half];
    logic [CntWidth-1:0]          w_coef_idx;
    logic signed [DataWidth-1:0]  w_x;
    logic signed [CoeffWidth-1:0] w_coef;
    logic signed [ProdWidth-1:0]  w_prod;
    logic signed [AccWidth-1:0]   w_prod_ext;

    logic signed [AccWidth-1:0]   r_acc_p1;
    logic                         r_acc_vld_p1;

    assign Ready_o  = (r_state == ST_IDLE);
    assign w_accept = DataNd_i && Ready_o;
    assign w_last   = (r_cnt == CntWidth'(Half - 1));

    // FSM state register.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: one pass per phase, each lasting Half MAC cycles.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_MAC0;
            ST_MAC0: if (w_last)   w_next_state = ST_MAC1;
            ST_MAC1: if (w_last)   w_next_state = ST_IDLE;
            default:               w_next_state = ST_IDLE;
        endcase
    end

    // Tap counter: runs 0..Half-1 in each MAC phase, parked at 0 when idle.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_cnt <= '0;
        end else if (r_state != ST_IDLE) begin
            r_cnt <= w_last ? '0 : r_cnt + CntWidth'(1);
        end
    end

    // ---- stage p0: sample delay line, newest sample at index 0 ----
    // Delay line advances only on an accepted sample.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            for (int i = 0; i < Half; i++) begin
                r_dl[i] <= '0;
            end
        end else if (w_accept) begin
            r_dl[0] <= Data_i;
            for (int i = 1; i < Half; i++) begin
                r_dl[i] <= r_dl[i-1];
            end
        end
    end

    // Odd phase reads the stored coefficients in reverse order.
    assign w_coef_idx = (r_state == ST_MAC1) ? (CntWidth'(Half - 1) - r_cnt) : r_cnt;
    assign w_x        = r_dl[r_cnt];
    assign w_coef     = CoeffWidth'(C_COEF[w_coef_idx]);
    assign w_prod     = w_x * w_coef;
    assign w_prod_ext = {{(AccWidth-ProdWidth){w_prod[ProdWidth-1]}}, w_prod};

    // ---- stage p1: accumulator, final value flagged after the last tap ----
    // Accumulate one product per cycle; the first tap of a phase reloads.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_acc_p1     <= '0;
            r_acc_vld_p1 <= 1'b0;
        end else begin
            r_acc_vld_p1 <= 1'b0;
            if (r_state != ST_IDLE) begin
                r_acc_p1     <= (r_cnt == '0) ? w_prod_ext : r_acc_p1 + w_prod_ext;
                r_acc_vld_p1 <= w_last;
            end
        end
    end

    // Sticky overrun: a strobe while busy is dropped and remembered.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_overrun <= 1'b0;
        end else if (DataNd_i && !Ready_o) begin
            r_overrun <= 1'b1;
        end
    end

    assign Overrun_o = r_overrun;

    interp_round_sat #(
        .AccWidth   (AccWidth),
        .DataWidth  (DataWidth),
        .RoundShift (RoundShift)
    ) u_round_sat (
        .i_clk  (Clk_i),
        .i_rst  (Rst_i),
        .i_vld  (r_acc_vld_p1),
        .i_acc  (r_acc_p1),
        .o_vld  (DataValid_o),
        .o_data (Data_o)
    );

endmodule

// File: tb/tb_interp_symmetric_filter.sv
// tb_interp_symmetric_filter
// Randomized scoreboard bench. The reference model convolves the accepted
// input history with the full 16-tap impulse response and rounds with
// integer arithmetic; a negedge monitor compares every output cycle.
// Build macro INTERP_FILTER_SATURATE_EN selects the clamp model.
`timescale 1ns/1ps
module tb_interp_symmetric_filter;

    localparam int DW   = 18;
    localparam int TAPS = 16;
    localparam int HALF = TAPS / 2;
    localparam int H [TAPS] = '{
        -600, -1500, 2500, 6000, -9000, -15000, 40000, 110000,
        110000, 40000, -15000, -9000, 6000, 2500, -1500, -600
    };

    typedef struct {
        int data;
        int edge_n;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] din;
    logic                 nd;
    logic                 rdy;
    logic signed [DW-1:0] dout;
    logic                 dvld;
    logic                 ovr;

    int   cyc = 0;
    exp_t sb [$];
    int   hist [HALF];
    int   acc_t    = -1000;
    int   ovr_edge = 1 << 30;
    int   exp_hold = 0;
    bit   mon_en   = 1'b0;
    int   n_cmp    = 0;
    int   n_fail   = 0;

    interp_symmetric_filter dut (
        .Clk_i       (clk),
        .Rst_i       (rst),
        .Data_i      (din),
        .DataNd_i    (nd),
        .Ready_o     (rdy),
        .Data_o      (dout),
        .DataValid_o (dvld),
        .Overrun_o   (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d, required %0d", name, cyc + 1, act, req);
        end
    endtask

    // Round half away from zero by 2^17, then clamp or wrap to 18 bits.
    function automatic int fit(input longint acc);
        longint mag;
        longint q;
        mag = (acc < 0) ? -acc : acc;
        q   = (mag + 65536) / 131072;
        if (acc < 0) q = -q;
`ifdef INTERP_FILTER_SATURATE_EN
        if (q > 131071)  q = 131071;
        if (q < -131072) q = -131072;
`else
        q = ((q % 262144) + 262144) % 262144;
        if (q >= 131072) q = q - 262144;
`endif
        return int'(q);
    endfunction

    // Busy for the 16 sampling edges after an accept.
    function automatic bit model_ready(input int e);
        return !(e >= acc_t + 1 && e <= acc_t + 16);
    endfunction

    task automatic model_accept(input int e, input int d);
        longint y0;
        longint y1;
        exp_t   it;
        y0 = 0;
        y1 = 0;
        for (int k = HALF - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
        for (int k = 0; k < HALF; k++) begin
            y0 += longint'(hist[k]) * longint'(H[2*k]);
            y1 += longint'(hist[k]) * longint'(H[2*k+1]);
        end
        it.data = fit(y0); it.edge_n = e + 10; sb.push_back(it);
        it.data = fit(y1); it.edge_n = e + 18; sb.push_back(it);
        acc_t = e;
    endtask

    task automatic model_reset();
        for (int k = 0; k < HALF; k++) hist[k] = 0;
        sb.delete();
        acc_t    = -1000;
        ovr_edge = 1 << 30;
        exp_hold = 0;
        mon_en   = 1'b1;
    endtask

    // Advance one clock and update the model with what that edge sampled.
    task automatic tick();
        int e;
        e = cyc + 1;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            check("rst_ready", rdy, 1);
            check("rst_valid", dvld, 0);
            check("rst_data", dout, 0);
            check("rst_overrun", ovr, 0);
        end else if (nd) begin
            if (model_ready(e)) model_accept(e, int'(din));
            else if (ovr_edge > e + 1) ovr_edge = e + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int d);
        int guard;
        guard = 0;
        while (!rdy && guard < 40) begin
            tick();
            guard++;
        end
        if (!rdy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: Ready_o=%0b after %0d cycles, required 1", rdy, guard);
        end
        din = DW'(d);
        nd  = 1'b1;
        tick();
        nd  = 1'b0;
    endtask

    task automatic pulse_nd();
        din = DW'($urandom);
        nd  = 1'b1;
        tick();
        nd  = 1'b0;
    endtask

    task automatic impulse();
        send(65536);
        for (int i = 0; i < HALF - 1; i++) send(0);
    endtask

    // Monitor: every cycle check handshake, sticky flag and output word.
    initial begin
        int   e;
        bit   ev;
        exp_t it;
        wait (mon_en);
        forever begin
            @(negedge clk);
            e = cyc + 1;
            check("ready", rdy, model_ready(e));
            check("overrun", ovr, (e >= ovr_edge));
            while (sb.size() > 0 && sb[0].edge_n < e) void'(sb.pop_front());
            ev = (sb.size() > 0 && sb[0].edge_n == e);
            check("valid", dvld, ev);
            if (dvld) begin
                if (sb.size() > 0) begin
                    it = sb.pop_front();
                    check("data", dout, it.data);
                    exp_hold = it.data;
                end
            end else begin
                check("hold", dout, exp_hold);
            end
        end
    end

    initial begin
        int guard;
        // Reset with a strobe present: the strobe must be ignored.
        rst = 1'b1;
        nd  = 1'b1;
        din = 18'sd1234;
        idle(3);
        rst = 1'b0;
        nd  = 1'b0;
        idle(1);

        // Impulse response, samples back-to-back.
        impulse();

        // Strobe 5 edges after an accept: dropped, overrun latches.
        send(1000);
        idle(4);
        pulse_nd();
        for (int i = 0; i < 4; i++) send(-2000 * i);

        // Full-scale DC.
        for (int i = 0; i < 20; i++) send(131071);

        // Random samples, random gaps, occasional strobes while busy.
        for (int i = 0; i < 30; i++) begin
            idle($urandom_range(0, 3));
            send(int'($signed(DW'($urandom))));
            if ($urandom_range(0, 4) == 0) begin
                idle($urandom_range(1, 12));
                pulse_nd();
            end
        end

        // Full-scale steps through the >1 gain path.
        for (int i = 0; i < 10; i++) send(-131072);
        for (int i = 0; i < 10; i++) send(131071);
        for (int i = 0; i < 10; i++) send(-131072);

        // Reset during MAC0 (with a strobe during reset), then impulse again.
        send(5000);
        idle(3);
        rst = 1'b1;
        nd  = 1'b1;
        tick();
        rst = 1'b0;
        nd  = 1'b0;
        idle(2);
        impulse();

        // Drain outstanding outputs.
        guard = 0;
        while (sb.size() > 0 && guard < 60) begin
            tick();
            guard++;
        end
        check("drain_pending", sb.size(), 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
